// File: rtl/uaz8_pkg.sv
// Shared encodings for the microUAZ8 control path:
// opcodes, ALU operations, sequencer states and instruction fields.
package uaz8_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int FA_MSB  = 5;
    localparam int FA_LSB  = 3;
    localparam int FB_MSB  = 2;
    localparam int FB_LSB  = 0;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10
    } state_t;

    // Non-ALU opcodes leave the ALU selector at ADD.
    function automatic logic [1:0] alu_of(input logic [2:0] opc);
        logic [1:0] op;
        op = ALU_ADD;
        case (opc)
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/uaz8_control_unit_if.sv
// Bundle between the control unit, program memory and datapath.
// master = control unit, slave = memory/datapath side.
interface uaz8_control_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic                Run;
    logic [8:0]          Instruction;
    logic                Data_Valid;
    logic                Zero_Flag;
    logic [PC_WIDTH-1:0] Address_Instruction_Bus;
    logic [7:0]          Address_Data_Bus;
    logic [2:0]          Rf_Addr_A;
    logic [2:0]          Rf_Addr_B;
    logic                Rf_We;
    logic                Rf_Src_Sel;
    logic [1:0]          Alu_Op;
    logic                Flag_We;
    logic                LE;
    logic [1:0]          State;

    modport master (
        input  Run, Instruction, Data_Valid, Zero_Flag,
        output Address_Instruction_Bus, Address_Data_Bus,
        output Rf_Addr_A, Rf_Addr_B, Rf_We, Rf_Src_Sel,
        output Alu_Op, Flag_We, LE, State
    );

    modport slave (
        output Run, Instruction, Data_Valid, Zero_Flag,
        input  Address_Instruction_Bus, Address_Data_Bus,
        input  Rf_Addr_A, Rf_Addr_B, Rf_We, Rf_Src_Sel,
        input  Alu_Op, Flag_We, LE, State
    );
endinterface

// File: rtl/uaz8_pc.sv
// Program counter: reset vector, load, increment with wrap, hold.
module uaz8_pc #(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uaz8_control_unit.sv
// microUAZ8 sequencer: FETCH/DECODE/EXECUTE FSM, instruction
// register and decode driving the datapath controls.
module uaz8_control_unit
    import uaz8_pkg::*;
#(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    uaz8_control_unit_if.master  bus
);

    state_t              state;
    state_t              state_next;
    logic [8:0]          ir;
    logic [2:0]          opc;
    logic [2:0]          fa;
    logic [2:0]          fb;
    logic                is_exec;
    logic                is_alu;
    logic                is_load;
    logic                is_store;
    logic                is_ldst;
    logic                done;
    logic                commit;
    logic                take_jump;
    logic                pc_inc;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign fa  = ir[FA_MSB:FA_LSB];
    assign fb  = ir[FB_MSB:FB_LSB];

    assign is_exec  = (state == ST_EXECUTE);
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);
    assign is_ldst  = is_load | is_store;
    assign is_alu   = (opc == OP_ADD) | (opc == OP_SUB)
                    | (opc == OP_AND) | (opc == OP_OR);

    // A LOAD without data keeps EXECUTE alive; reset aborts any write.
    assign done   = is_exec & ~(is_load & ~bus.Data_Valid);
    assign commit = done & ~Rst;

    assign take_jump = (opc == OP_JMP)
                     | ((opc == OP_JZ) & bus.Zero_Flag);
    assign pc_load   = commit & take_jump;
    assign pc_inc    = commit & ~take_jump;
    assign target    = PC_WIDTH'({fa, fb});

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && bus.Run) begin
                ir <= bus.Instruction;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:   if (bus.Run) state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: if (done) state_next = ST_FETCH;
            default:    state_next = ST_FETCH;
        endcase
    end

    uaz8_pc #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk    (Clk),
        .rst    (Rst),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (target),
        .pc     (pc)
    );

    assign bus.Address_Instruction_Bus = pc;
    assign bus.Address_Data_Bus = is_ldst ? {5'b0, fb} : 8'h00;
    assign bus.Rf_Addr_A  = fa;
    assign bus.Rf_Addr_B  = fb;
    assign bus.Alu_Op     = alu_of(opc);
    assign bus.Rf_We      = commit & (is_alu | is_load);
    assign bus.Flag_We    = commit & is_alu;
    assign bus.LE         = commit & is_store;
    assign bus.Rf_Src_Sel = is_exec & is_load;
    assign bus.State      = state;

endmodule

// File: tb/tb_uaz8_control_unit.sv
// Directed bench for uaz8_control_unit: vector table plus
// reset, LOAD stall, PC wrap and Run-gating sequences.
module tb_uaz8_control_unit;

    typedef struct {
        logic [8:0] instr;
        logic       zf;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] alu;
        logic       we;
        logic       fw;
        logic       le;
        logic       src;
        logic [7:0] adb;
        logic [7:0] pc;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[11];
    vec_t v;

    uaz8_control_unit_if #(.PC_WIDTH(8)) bus ();

    uaz8_control_unit #(
        .PC_WIDTH     (8),
        .RESET_VECTOR (8'h00)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " we"}, 32'(bus.Rf_We), 0);
        chk({nm, " fw"}, 32'(bus.Flag_We), 0);
        chk({nm, " le"}, 32'(bus.LE), 0);
    endtask

    // Called at a FETCH sample point; ends at the next FETCH.
    task automatic run_vec(input vec_t t, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        bus.Instruction = t.instr;
        bus.Zero_Flag   = t.zf;
        bus.Data_Valid  = 1'b1;
        chk({nm, " fetch st"}, 32'(bus.State), 0);
        step();
        chk({nm, " decode st"}, 32'(bus.State), 1);
        chk_quiet({nm, " decode"});
        chk({nm, " decode adb"}, 32'(bus.Address_Data_Bus),
            32'(t.adb));
        step();
        chk({nm, " exec st"}, 32'(bus.State), 2);
        chk({nm, " a"}, 32'(bus.Rf_Addr_A), 32'(t.a));
        chk({nm, " b"}, 32'(bus.Rf_Addr_B), 32'(t.b));
        chk({nm, " alu"}, 32'(bus.Alu_Op), 32'(t.alu));
        chk({nm, " we"}, 32'(bus.Rf_We), 32'(t.we));
        chk({nm, " fw"}, 32'(bus.Flag_We), 32'(t.fw));
        chk({nm, " le"}, 32'(bus.LE), 32'(t.le));
        chk({nm, " src"}, 32'(bus.Rf_Src_Sel), 32'(t.src));
        chk({nm, " adb"}, 32'(bus.Address_Data_Bus), 32'(t.adb));
        step();
        chk({nm, " next st"}, 32'(bus.State), 0);
        chk({nm, " pc"}, 32'(bus.Address_Instruction_Bus),
            32'(t.pc));
    endtask

    initial begin
        int n;
        logic [7:0] pc0;

        // instr, zf, a, b, alu, we, fw, le, src, adb, pc-after
        tbl[0]  = '{9'b010_010_011, 0, 2, 3, 0, 1, 1, 0, 0, 8'h00, 8'h01};
        tbl[1]  = '{9'b011_001_111, 0, 1, 7, 1, 1, 1, 0, 0, 8'h00, 8'h02};
        tbl[2]  = '{9'b100_101_000, 0, 5, 0, 2, 1, 1, 0, 0, 8'h00, 8'h03};
        tbl[3]  = '{9'b101_011_011, 0, 3, 3, 3, 1, 1, 0, 0, 8'h00, 8'h04};
        tbl[4]  = '{9'b001_010_110, 0, 2, 6, 0, 0, 0, 1, 0, 8'h06, 8'h05};
        tbl[5]  = '{9'b000_110_001, 0, 6, 1, 0, 1, 0, 0, 1, 8'h01, 8'h06};
        tbl[6]  = '{9'b111_100_100, 1, 4, 4, 0, 0, 0, 0, 0, 8'h00, 8'h24};
        tbl[7]  = '{9'b111_100_100, 0, 4, 4, 0, 0, 0, 0, 0, 8'h00, 8'h25};
        tbl[8]  = '{9'b110_000_011, 0, 0, 3, 0, 0, 0, 0, 0, 8'h00, 8'h03};
        tbl[9]  = '{9'b110_000_011, 0, 0, 3, 0, 0, 0, 0, 0, 8'h00, 8'h03};
        tbl[10] = '{9'b111_000_101, 1, 0, 5, 0, 0, 0, 0, 0, 8'h00, 8'h05};

        bus.Run         = 1'b1;
        bus.Instruction = 9'h000;
        bus.Data_Valid  = 1'b0;
        bus.Zero_Flag   = 1'b0;

        Rst = 1'b1;
        step();
        step();
        chk("rst pc", 32'(bus.Address_Instruction_Bus), 0);
        chk("rst st", 32'(bus.State), 0);
        chk_quiet("rst");
        chk("rst src", 32'(bus.Rf_Src_Sel), 0);
        chk("rst alu", 32'(bus.Alu_Op), 0);
        chk("rst adb", 32'(bus.Address_Data_Bus), 0);
        chk("rst a", 32'(bus.Rf_Addr_A), 0);
        chk("rst b", 32'(bus.Rf_Addr_B), 0);
        Rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // LOAD with four data-less EXECUTE cycles
        pc0 = bus.Address_Instruction_Bus;
        bus.Instruction = 9'b000_110_001;
        bus.Data_Valid  = 1'b0;
        n = 0;
        step(); n++;
        for (int i = 0; i < 4; i++) begin
            step(); n++;
            chk($sformatf("stall%0d st", i), 32'(bus.State), 2);
            chk($sformatf("stall%0d we", i), 32'(bus.Rf_We), 0);
            chk($sformatf("stall%0d src", i), 32'(bus.Rf_Src_Sel), 1);
            chk($sformatf("stall%0d adb", i),
                32'(bus.Address_Data_Bus), 1);
            chk($sformatf("stall%0d pc", i),
                32'(bus.Address_Instruction_Bus), 32'(pc0));
        end
        step(); n++;
        chk("stall last we", 32'(bus.Rf_We), 0);
        bus.Data_Valid = 1'b1;
        #1;
        chk("load done we", 32'(bus.Rf_We), 1);
        chk("load done src", 32'(bus.Rf_Src_Sel), 1);
        step(); n++;
        bus.Data_Valid = 1'b0;
        chk("load cycles", 32'(n), 7);
        chk("load st", 32'(bus.State), 0);
        chk("load pc", 32'(bus.Address_Instruction_Bus),
            32'(pc0 + 8'h01));

        // Reach PC 0xFF, then a not-taken JZ must wrap to 0x00
        v = '{9'b110_111_111, 0, 7, 7, 0, 0, 0, 0, 0, 8'h00, 8'h3f};
        run_vec(v, 11);
        bus.Instruction = 9'b010_000_000;
        for (int i = 0; i < 192; i++) begin
            step();
            step();
            step();
        end
        chk("pre-wrap pc", 32'(bus.Address_Instruction_Bus), 8'hff);
        v = '{9'b111_100_100, 0, 4, 4, 0, 0, 0, 0, 0, 8'h00, 8'h00};
        run_vec(v, 12);

        // Reset while a LOAD is stalled
        bus.Instruction = 9'b000_110_001;
        bus.Data_Valid  = 1'b0;
        step();
        step();
        step();
        chk("abort st", 32'(bus.State), 2);
        Rst = 1'b1;
        #1;
        chk("abort we", 32'(bus.Rf_We), 0);
        step();
        Rst = 1'b0;
        chk("abort st after", 32'(bus.State), 0);
        chk("abort pc", 32'(bus.Address_Instruction_Bus), 0);
        chk("abort we after", 32'(bus.Rf_We), 0);

        // Run low: sequencer parks in FETCH
        bus.Run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle%0d st", i), 32'(bus.State), 0);
            chk($sformatf("idle%0d pc", i),
                32'(bus.Address_Instruction_Bus), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
